// File: rtl/pcie_byte_unstripe.sv
// Deskews four PCIe lanes on alignment markers and merges them into one word.
// Latency: data_valid two edges after a zero-skew word set is presented.
// Backpressure: none; a lane running DESKEW_DEPTH words ahead overflows, flushes and re-searches.
module pcie_byte_unstripe #(
  parameter int DATA_WIDTH   = 128,
  parameter int LANE_WIDTH   = 32,
  parameter int DESKEW_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANE_WIDTH-1:0] lane0,
  input  logic [LANE_WIDTH-1:0] lane1,
  input  logic [LANE_WIDTH-1:0] lane2,
  input  logic [LANE_WIDTH-1:0] lane3,
  input  logic [3:0]            lane_valid,
  input  logic [3:0]            lane_sync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  aligned,
  output logic                  deskew_err
);

  localparam int AW = $clog2(DESKEW_DEPTH);

  typedef enum logic {SEARCH = 1'b0, ALIGNED = 1'b1} state_t;
  typedef logic [LANE_WIDTH:0] entry_t;  // {sync, data}

  state_t                state;
  state_t                state_nxt;
  logic                  run;
  logic [LANE_WIDTH-1:0] lane_dat [4];
  entry_t                mem [4][DESKEW_DEPTH];
  logic [AW:0]           wp [4];
  logic [AW:0]           rp [4];
  logic [LANE_WIDTH-1:0] head_dat [4];
  logic [3:0]            empty;
  logic [3:0]            full;
  logic [3:0]            head_sync;
  logic [3:0]            wr;
  logic [3:0]            ovf;
  logic                  pop;
  logic                  emit;
  logic                  mix;
  logic                  err;

  assign lane_dat[0] = lane0;
  assign lane_dat[1] = lane1;
  assign lane_dat[2] = lane2;
  assign lane_dat[3] = lane3;

  // The state flop is the aligned flag, so it drops on the same edge deskew_err rises.
  assign aligned = (state == ALIGNED);

  // Per-lane FIFO status and write acceptance. In SEARCH a FIFO only becomes
  // non-empty through a marker, so "non-empty" means "marker already seen".
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]     = (wp[i] == rp[i]);
      full[i]      = (wp[i][AW-1:0] == rp[i][AW-1:0]) && (wp[i][AW] != rp[i][AW]);
      head_sync[i] = mem[i][rp[i][AW-1:0]][LANE_WIDTH];
      head_dat[i]  = mem[i][rp[i][AW-1:0]][LANE_WIDTH-1:0];
      wr[i]        = run && lane_valid[i] && ((state == ALIGNED) || !empty[i] || lane_sync[i]);
    end
  end

  // Pop/merge decision, error detection and next state.
  always_comb begin
    pop  = 1'b0;
    emit = 1'b0;
    mix  = 1'b0;
    if (&(~empty)) begin
      if (&head_sync) begin
        pop = 1'b1;
      end else if (state == ALIGNED) begin
        if (~|head_sync) begin
          pop  = 1'b1;
          emit = 1'b1;
        end else begin
          mix = 1'b1;
        end
      end
    end
    // A simultaneous pop frees the slot, so a full FIFO only overflows without one.
    ovf       = wr & full & {4{~pop}};
    err       = mix | (|ovf);
    state_nxt = state;
    if (err) begin
      state_nxt = SEARCH;
    end else if (pop) begin
      state_nxt = ALIGNED;
    end
  end

  // Reset release is retimed: the first edge after release only arms the write path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  // FIFO pointers; any error flushes every lane and drops that cycle's words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (err) begin
          wp[i] <= '0;
          rp[i] <= '0;
        end else begin
          if (wr[i]) wp[i] <= wp[i] + (AW+1)'(1);
          if (pop)   rp[i] <= rp[i] + (AW+1)'(1);
        end
      end
    end
  end

  // FIFO storage, no reset needed: occupancy is carried by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr[i] && !err) mem[i][wp[i][AW-1:0]] <= {lane_sync[i], lane_dat[i]};
    end
  end

  // Registered outputs; data_out holds its last merged word between pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      deskew_err <= 1'b0;
    end else begin
      data_valid <= emit;
      deskew_err <= err;
      if (emit) data_out <= {head_dat[3], head_dat[2], head_dat[1], head_dat[0]};
    end
  end

endmodule
